serial_add_scheduler: RTL and testbench

//  Shares one serial adder datapath (A/B/start/resetn/clock -> 9-bit sum, no done flag) among NUM_REQ requesters.

---
 rtl/serial_sched_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/serial_add_scheduler.sv | 146 ++++++++++++++
 tb/tb_serial_add_scheduler.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_sched_pkg.sv
// -----------------------------------------------------------------------------
// serial_sched_pkg
// Shared definitions for the serial adder scheduler: FSM state encoding,
// default sizes and the derivation of the adder start-hold length.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_sched_pkg;

    // Scheduler FSM encoding; the values are visible on the debug state output.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } sched_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    // The adder needs one load cycle plus one shift per sum bit (WIDTH+1 bits),
    // all with start held high.
    function automatic int add_cycles_for(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the winner is the first asserted request at
// or after the pointer, wrapping past NUM_REQ-1 back to 0. The pointer register
// itself lives in the parent.
// Ports:
//   req         in   NUM_REQ   request vector
//   pointer     in   ID_W      highest-priority index this cycle
//   win_onehot  out  NUM_REQ   one-hot winner (all zero when no request)
//   win_idx     out  ID_W      winner index (0 when no request)
//   win_valid   out  1         at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    pointer,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [ID_W-1:0]    win_idx,
    output logic               win_valid
);

    // One extra bit so pointer+offset cannot overflow before the wrap.
    logic [ID_W:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        cand       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, pointer} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!win_valid && req[cand[ID_W-1:0]]) begin
                win_valid                   = 1'b1;
                win_idx                     = cand[ID_W-1:0];
                win_onehot[cand[ID_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_add_scheduler.sv
// -----------------------------------------------------------------------------
// serial_add_scheduler
// Shares one serial adder (A/B/start/resetn -> WIDTH+1 sum, no done flag) among
// NUM_REQ requesters. Round-robin pick, operand capture, fixed-length start
// sequencing, sum capture and tagged result return.
//
// Handshake: a requester holds req[i] high with stable operands; the scheduler
// samples req only in IDLE. grant[i] is a one-cycle pulse meaning "operands
// taken", after which req[i] may drop. result_valid is a one-cycle pulse with
// result/result_id valid in that cycle; there is no back-pressure on results.
//
// Ports:
//   clock         in   1               rising-edge clock
//   reset         in   1               synchronous, active-high
//   req           in   NUM_REQ         level requests
//   a_in, b_in    in   NUM_REQ*WIDTH   operands, requester i at [i*WIDTH +: WIDTH]
//   grant         out  NUM_REQ         one-hot operand-taken pulse
//   busy          out  1               state != IDLE
//   result        out  WIDTH+1         last captured sum
//   result_id     out  ID_W            owner of result
//   result_valid  out  1               result pulse
//   add_a, add_b  out  WIDTH           adder operands, stable through RUN
//   add_start     out  1               adder start, high for ADD_CYCLES cycles
//   add_resetn    out  1               adder reset, registered ~reset
//   add_sum       in   WIDTH+1         adder sum
//   state_dbg     out  2               FSM state (debug)
// -----------------------------------------------------------------------------
module serial_add_scheduler
    import serial_sched_pkg::*;
#(
    parameter  int NUM_REQ    = DEF_NUM_REQ,
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int ADD_CYCLES = add_cycles_for(WIDTH),
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [WIDTH:0]           result,
    output logic [ID_W-1:0]          result_id,
    output logic                     result_valid,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_start,
    output logic                     add_resetn,
    input  logic [WIDTH:0]           add_sum,
    output logic [1:0]               state_dbg
);

    localparam int CNT_W = $clog2(ADD_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_CYCLES - 1);

    sched_state_t        state, next_state;
    logic [CNT_W-1:0]    count;
    logic [ID_W-1:0]     pointer;
    logic [ID_W-1:0]     op_id;

    logic [NUM_REQ-1:0]  win_onehot;
    logic [ID_W-1:0]     win_idx;
    logic                win_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req        (req),
        .pointer    (pointer),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_valid  (win_valid)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (win_valid) next_state = ST_RUN;
            ST_RUN:   if (count == CNT_LAST) next_state = ST_DRAIN;
            ST_DRAIN: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Start follows the state directly so it falls in the first cycle after a
    // reset is sampled, and in DRAIN, which returns the adder to its wait state
    // before the next IDLE.
    assign add_start = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // ---------------- datapath ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            grant        <= '0;
            result       <= '0;
            result_id    <= '0;
            result_valid <= 1'b0;
            add_a        <= '0;
            add_b        <= '0;
            pointer      <= '0;
            op_id        <= '0;
            count        <= '0;
        end else begin
            grant        <= '0;
            result_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        add_a   <= a_in[win_idx*WIDTH +: WIDTH];
                        add_b   <= b_in[win_idx*WIDTH +: WIDTH];
                        op_id   <= win_idx;
                        grant   <= win_onehot;
                        pointer <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + ID_W'(1);
                        count   <= '0;
                    end
                end
                ST_RUN: begin
                    count <= count + CNT_W'(1);
                end
                ST_DRAIN: begin
                    result       <= add_sum;
                    result_id    <= op_id;
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Adder reset is low while reset is sampled and releases one cycle later.
    always_ff @(posedge clock) begin
        add_resetn <= ~reset;
    end

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;

    localparam int N          = 4;
    localparam int W          = 8;
    localparam int ID_W       = 2;
    localparam int ADD_CYCLES = W + 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req   = '0;
    logic [N*W-1:0]   a_in  = '0;
    logic [N*W-1:0]   b_in  = '0;
    logic [N-1:0]     grant;
    logic             busy;
    logic [W:0]       result;
    logic [ID_W-1:0]  result_id;
    logic             result_valid;
    logic [W-1:0]     add_a, add_b;
    logic             add_start, add_resetn;
    logic [W:0]       add_sum;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    serial_add_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .a_in         (a_in),
        .b_in         (b_in),
        .grant        (grant),
        .busy         (busy),
        .result       (result),
        .result_id    (result_id),
        .result_valid (result_valid),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_start    (add_start),
        .add_resetn   (add_resetn),
        .add_sum      (add_sum),
        .state_dbg    (state_dbg)
    );

    // ---------------- serial adder datapath (bit-serial, LSB first) ----------------
    logic [W-1:0] ad_a, ad_b;
    logic         ad_c;
    int           ad_cnt;

    always @(posedge clock or negedge add_resetn) begin
        if (!add_resetn) begin
            ad_cnt  <= 0;
            ad_a    <= '0;
            ad_b    <= '0;
            ad_c    <= 1'b0;
            add_sum <= '0;
        end else if (add_start) begin
            if (ad_cnt == 0) begin
                ad_a   <= add_a;
                ad_b   <= add_b;
                ad_c   <= 1'b0;
                ad_cnt <= 1;
            end else if (ad_cnt <= W + 1) begin
                add_sum <= {ad_a[0] ^ ad_b[0] ^ ad_c, add_sum[W:1]};
                ad_c    <= (ad_a[0] & ad_b[0]) | (ad_c & (ad_a[0] ^ ad_b[0]));
                ad_a    <= ad_a >> 1;
                ad_b    <= ad_b >> 1;
                ad_cnt  <= ad_cnt + 1;
            end
        end else begin
            ad_cnt <= 0;
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Tracks, per clock edge, whether the shared adder is free, whom round-robin
    // picks when it is, and when each sum is due back.
    bit                 sb_on = 0;
    int                 m_left = 0;
    int                 m_ptr  = 0;
    logic [W-1:0]       m_a = '0, m_b = '0;
    logic [N-1:0]       exp_grant = '0;
    logic               exp_resetn = 1'b0;
    logic [W:0]         m_result = '0;
    logic [ID_W-1:0]    m_result_id = '0;
    logic               exp_rv;
    logic [ID_W+W:0]    exp_q[$];
    int                 due_q[$];

    always @(posedge clock) begin
        int w;
        cyc++;
        exp_resetn = !reset;
        exp_grant  = '0;
        if (reset) begin
            sb_on       = 1;
            m_left      = 0;
            m_ptr       = 0;
            m_a         = '0;
            m_b         = '0;
            m_result    = '0;
            m_result_id = '0;
            exp_q.delete();
            due_q.delete();
        end else if (m_left > 0) begin
            m_left--;
        end else if (req != 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            m_a          = a_in[w*W +: W];
            m_b          = b_in[w*W +: W];
            exp_grant[w] = 1'b1;
            m_ptr        = (w + 1) % N;
            m_left       = ADD_CYCLES + 1;
            exp_q.push_back({ID_W'(w), (W+1)'(m_a) + (W+1)'(m_b)});
            due_q.push_back(cyc + ADD_CYCLES + 1);
        end
    end

    // ---------------- scoreboard (every cycle, away from the active edge) ----------------
    always @(negedge clock) begin
        if (sb_on) begin
            exp_rv = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_rv = 1'b1;
                {m_result_id, m_result} = exp_q.pop_front();
                void'(due_q.pop_front());
            end
            check("sb_grant",        64'(grant),        64'(exp_grant));
            check("sb_busy",         64'(busy),         64'(m_left > 0));
            check("sb_add_start",    64'(add_start),    64'(m_left > 1));
            check("sb_result_valid", 64'(result_valid), 64'(exp_rv));
            check("sb_result",       64'(result),       64'(m_result));
            check("sb_result_id",    64'(result_id),    64'(m_result_id));
            check("sb_add_a",        64'(add_a),        64'(m_a));
            check("sb_add_b",        64'(add_b),        64'(m_b));
            check("sb_add_resetn",   64'(add_resetn),   64'(exp_resetn));
        end
    end

    // Operands must not move while the adder is running.
    logic [W-1:0] prev_a, prev_b;
    logic         prev_start = 1'b0;
    always @(negedge clock) begin
        if (prev_start && add_start) begin
            check("operand_stable_a", 64'(add_a), 64'(prev_a));
            check("operand_stable_b", 64'(add_b), 64'(prev_b));
        end
        prev_a     = add_a;
        prev_b     = add_b;
        prev_start = add_start;
    end

    // ---------------- grant log ----------------
    int glog[$];
    int gcyc[$];
    always @(negedge clock) begin
        if (grant != 0) begin
            for (int k = 0; k < N; k++) if (grant[k]) glog.push_back(k);
            gcyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[i*W +: W] = a;
        b_in[i*W +: W] = b;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == 0 && n < budget);
        check("grant_timeout", 64'(grant != 0), 64'(1));
    endtask

    task automatic wait_rv(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!result_valid && n < budget);
        check("result_valid_timeout", 64'(result_valid), 64'(1));
    endtask

    task automatic wait_glog(input int count, input int budget);
        int n;
        n = 0;
        while (glog.size() < count && n < budget) begin
            tick();
            n++;
        end
        check("grant_count_timeout", 64'(glog.size() >= count), 64'(1));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp_sum;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int n1, n2;
        int exp_seq2[4];
        int exp_seq3[7];

        vecs[0] = '{id: 0, a: 8'hFF, b: 8'h01, exp_sum: 9'h100};
        vecs[1] = '{id: 1, a: 8'hFF, b: 8'hFF, exp_sum: 9'h1FE};
        vecs[2] = '{id: 2, a: 8'h00, b: 8'h00, exp_sum: 9'h000};
        vecs[3] = '{id: 3, a: 8'h80, b: 8'h80, exp_sum: 9'h100};
        vecs[4] = '{id: 1, a: 8'h5A, b: 8'h3C, exp_sum: 9'h096};
        exp_seq2 = '{0, 1, 2, 3};
        exp_seq3 = '{0, 2, 0, 2, 0, 1, 2};

        // ---- reset state ----
        reset = 1'b1;
        repeat (2) tick();
        check("rst_grant",        64'(grant),        64'(0));
        check("rst_busy",         64'(busy),         64'(0));
        check("rst_result",       64'(result),       64'(0));
        check("rst_result_id",    64'(result_id),    64'(0));
        check("rst_result_valid", 64'(result_valid), 64'(0));
        check("rst_add_start",    64'(add_start),    64'(0));
        check("rst_add_a",        64'(add_a),        64'(0));
        check("rst_add_b",        64'(add_b),        64'(0));
        check("rst_add_resetn",   64'(add_resetn),   64'(0));
        check("rst_state",        64'(state_dbg),    64'(2'b00));
        reset = 1'b0;
        tick();
        check("rst_release_add_resetn", 64'(add_resetn), 64'(1));

        // ---- single-requester table: latency, sum, id ----
        foreach (vecs[i]) begin
            set_ops(vecs[i].id, vecs[i].a, vecs[i].b);
            req = '0;
            req[vecs[i].id] = 1'b1;
            wait_grant(5, n1);
            check("vec_grant_latency", 64'(n1), 64'(1));
            check("vec_grant_onehot", 64'(grant), 64'(1 << vecs[i].id));
            req = '0;
            wait_rv(20, n2);
            check("vec_result_latency", 64'(n1 + n2), 64'(ADD_CYCLES + 2));
            check("vec_result", 64'(result), 64'(vecs[i].exp_sum));
            check("vec_result_id", 64'(result_id), 64'(vecs[i].id));
            tick();
        end

        // ---- all four requesting: order 0,1,2,3 spaced ADD_CYCLES+2 ----
        do_reset(2);
        for (int i = 0; i < N; i++) set_ops(i, 8'(16 * (i + 1) + 3), 8'(200 - 7 * i));
        glog.delete();
        gcyc.delete();
        req = 4'b1111;
        wait_glog(4, 80);
        req = '0;
        for (int i = 0; i < 4 && i < glog.size(); i++) check("rr_all_order", 64'(glog[i]), 64'(exp_seq2[i]));
        for (int i = 1; i < 4 && i < gcyc.size(); i++) check("rr_all_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'(ADD_CYCLES + 2));
        repeat (15) tick();

        // ---- req 0 and 2 held, req 1 joins later ----
        do_reset(2);
        glog.delete();
        req = 4'b0101;
        wait_glog(4, 80);
        req = 4'b0111;
        wait_glog(7, 60);
        req = '0;
        for (int i = 0; i < 7 && i < glog.size(); i++) check("rr_join_order", 64'(glog[i]), 64'(exp_seq3[i]));
        repeat (15) tick();

        // ---- reset mid-RUN aborts op; pointer back to 0 ----
        set_ops(2, 8'h12, 8'h34);
        set_ops(3, 8'h7F, 8'h81);
        req = 4'b0100;
        wait_grant(5, n1);
        req = '0;
        repeat (5) tick();
        check("abort_in_run", 64'(state_dbg), 64'(2'b01));
        reset = 1'b1;
        tick();
        check("abort_state_idle", 64'(state_dbg), 64'(2'b00));
        check("abort_add_start", 64'(add_start), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        n2 = 0;
        repeat (15) begin
            tick();
            if (result_valid) n2++;
        end
        check("abort_no_result", 64'(n2), 64'(0));
        req = 4'b1100;
        wait_grant(5, n1);
        check("abort_pointer_zero", 64'(grant), 64'(4'b0100));
        req = '0;
        wait_rv(20, n2);
        check("abort_next_result", 64'(result), 64'(9'h046));
        tick();
        req = 4'b1000;
        wait_grant(5, n1);
        check("abort_req3_grant", 64'(grant), 64'(4'b1000));
        req = '0;
        wait_rv(20, n2);
        check("abort_req3_result", 64'(result), 64'(9'h100));
        check("abort_req3_id", 64'(result_id), 64'(3));
        tick();

        // ---- req pulsed only during DRAIN is never granted ----
        set_ops(0, 8'h01, 8'h02);
        req = 4'b0001;
        wait_grant(5, n1);
        req = '0;
        repeat (10) tick();
        check("drain_state", 64'(state_dbg), 64'(2'b10));
        req = 4'b0010;
        tick();
        req = '0;
        glog.delete();
        repeat (20) tick();
        check("drain_pulse_not_granted", 64'(glog.size()), 64'(0));

        // ---- randomized traffic against the model ----
        for (int it = 0; it < 60; it++) begin
            req = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) set_ops(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            if (it == 30) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat ($urandom_range(1, 30)) tick();
        end
        req = '0;
        repeat (15) tick();
        check("sb_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
